rgb_led_fade_seq: RTL and testbench
===================================

Name: rgb_led_fade_seq

Overview:
- Parametrised successor to the fixed 3×8-bit RGB fade generator.
- Drives an N-channel LED level vector as an Avalon-ST source.
- Ramps one channel, or all channels together, up and down at a runtime-programmable step rate.
- Supports four sequencing modes, a run enable, an end-of-cycle pulse and full valid/ready backpressure. Sits between the Qsys control fabric and the PWM/LED sink.

Parameters:
- CHANNELS, 3: number of LED channels. Must be ≥1.
- WIDTH, 8: bits per channel level. MAX = 2^WIDTH-1.
- DIV_W, 19: width of the step-divider input.

Ports:
- csi_MCLK_clk  in  1  system clock.
- rsi_MRST_reset  in  1  synchronous, active-high reset, sampled on the rising edge of csi_MCLK_clk.
- coe_EN  in  1  run enable.
- coe_MODE  in  2  0=SEQ, 1=ALL, 2=SAW, 3=HOLD.
- coe_STEP_DIV  in  DIV_W  one level step every STEP_DIV+1 clocks.
- aso_LEDS_data  out  CHANNELS*WIDTH  level vector. Channel 0 is in the MSBs; channel i occupies bits [(CHANNELS-i)*WIDTH-1 -: WIDTH].
- aso_LEDS_valid  out  1  data holds an untransferred frame.
- aso_LEDS_ready  in  1  sink accepts the frame.
- coe_CYCLE_DONE  out  1  one-clock pulse at the end of a full sequence.

Behaviour:
- Reset, synchronous, active-high:
  - state=IDLE, ch=0, all levels 0, prescaler 0, mode_q=0.
  - aso_LEDS_data=0, aso_LEDS_valid=1 (initial zero frame), coe_CYCLE_DONE=0.
- Reset asserted mid-ramp takes effect on the next clock edge with the same values; any pending frame is discarded.
- Handshake:
  - A transfer occurs on a clock where valid and ready are both 1.
  - Every level change sets valid=1 on the same edge the new data is registered.
  - After a transfer with no simultaneous level change, valid=0 next clock.
  - While valid=1 and ready=0 (stall): data is held stable, the prescaler freezes, no level change occurs and the FSM does not advance.
- Prescaler:
  - pre_cnt counts 0..coe_STEP_DIV.
  - tick=1 when pre_cnt==coe_STEP_DIV and not stalled; pre_cnt then wraps to 0.
  - STEP_DIV=0 gives a tick every unstalled clock.
  - STEP_DIV is read live. If it is lowered below pre_cnt, pre_cnt counts on and wraps at the DIV_W boundary; no special handling.
- FSM states: IDLE, RAMP_UP, RAMP_DOWN, ADVANCE.
- IDLE:
  - If coe_EN=1: latch mode_q=coe_MODE, ch=0, pre_cnt=0, go to RAMP_UP.
  - Mode is only latched here, so mode changes take effect from the next sequence.
- RAMP_UP:
  - On tick, the active level(s) +1.
  - The tick that reaches MAX moves to RAMP_DOWN, except in SAW, where it moves to ADVANCE.
  - Active levels are channel ch (SEQ/SAW) or all channels (ALL).
- RAMP_DOWN:
  - On tick, the active level(s) -1.
  - The tick that reaches 0 moves to ADVANCE.
- ADVANCE (one clock, skipped while stalled):
  - SAW: channel ch is cleared to 0, producing a new frame.
  - If ch==CHANNELS-1, or mode_q=ALL: ch=0, pulse coe_CYCLE_DONE, and re-latch mode_q from coe_MODE. Otherwise ch=ch+1.
  - pre_cnt=0. Next state is RAMP_UP if coe_EN=1, else IDLE.
- HOLD: the FSM stays in RAMP_UP, no ticks modify levels and there is no CYCLE_DONE. Exit is via coe_EN=0.
- coe_EN=0 while in RAMP_UP/RAMP_DOWN (HOLD included): go to IDLE on the next unstalled clock and clear all levels to 0. A frame is generated only if any level was nonzero.
- Arithmetic:
  - Levels are WIDTH bits, saturating by construction: never incremented past MAX or decremented below 0.
  - ch is ceil(log2(CHANNELS)) bits, minimum 1.
- Timing, SEQ, no stalls: per channel 2*MAX*(STEP_DIV+1)+1 clocks from RAMP_UP entry to the next RAMP_UP.
- coe_CYCLE_DONE and a level frame may coincide. They are independent.

Test Plan:
- Reset then EN=0, ready=1 → data=0, valid=1 for the first clock then 0; CYCLE_DONE never pulses.
- CHANNELS=3, WIDTH=4, STEP_DIV=0, MODE=0, EN=1, ready=1:
  - Channel 0 reaches 0xF (data=0xF00) 15 clocks after RAMP_UP entry, then returns to 0.
  - Channel 1 (data=0x0F0) and channel 2 (data=0x00F) follow in turn.
  - CYCLE_DONE pulses once every 93 clocks.
- Same setup with MODE=1 → data 0x000→0xFFF→0x000; CYCLE_DONE every 31 clocks.
- Same setup with MODE=2 → channel 0 ramps 0..F, then the frame 0x000 follows; CYCLE_DONE every 48 clocks.
- STEP_DIV=3 with ready held low for 10 clocks mid-ramp:
  - data stays frozen and valid stays 1 throughout.
  - After ready rises, steps resume with 4-clock spacing and no level is skipped.
- EN dropped while channel 1 is at 0x9 → IDLE, data=0x000 frame. Assert rsi_MRST_reset mid-ramp → next clock data=0, valid=1, state IDLE.

Source files
------------

// File: rtl/rgb_led_fade_seq_if.sv
// Avalon-ST level-vector link between the fade sequencer (master) and the
// PWM/LED sink (slave).
//   aso_LEDS_data  : packed channel levels, channel 0 in the MSBs
//   aso_LEDS_valid : data holds a frame the sink has not yet taken
//   aso_LEDS_ready : sink accepts the frame on this clock
interface rgb_led_fade_seq_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] aso_LEDS_data;
  logic              aso_LEDS_valid;
  logic              aso_LEDS_ready;

  modport master (output aso_LEDS_data, output aso_LEDS_valid, input aso_LEDS_ready);
  modport slave  (input aso_LEDS_data, input aso_LEDS_valid, output aso_LEDS_ready);
endinterface

// File: rtl/rgb_led_fade_seq.sv
// N-channel LED fade sequencer with an Avalon-ST level output.
// Ramps one channel (SEQ/SAW) or every channel together (ALL) up and down,
// one level step every coe_STEP_DIV+1 unstalled clocks. HOLD parks the
// sequence until coe_EN drops.
//   csi_MCLK_clk   : clock
//   rsi_MRST_reset : synchronous active-high reset
//   coe_EN         : run enable
//   coe_MODE       : 0=SEQ 1=ALL 2=SAW 3=HOLD, latched at sequence start
//   coe_STEP_DIV   : step divider, read live
//   leds           : level vector stream (master side)
//   coe_CYCLE_DONE : one-clock pulse when a full sequence completes
module rgb_led_fade_seq #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 8,
  parameter int DIV_W    = 19
) (
  input  logic             csi_MCLK_clk,
  input  logic             rsi_MRST_reset,
  input  logic             coe_EN,
  input  logic [1:0]       coe_MODE,
  input  logic [DIV_W-1:0] coe_STEP_DIV,
  rgb_led_fade_seq_if.master leds,
  output logic             coe_CYCLE_DONE
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [1:0] M_ALL = 2'd1, M_SAW = 2'd2, M_HOLD = 2'd3;

  typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, ADVANCE} state_t;

  state_t             state_q;
  logic [CH_W-1:0]    ch_q;
  logic [1:0]         mode_q;
  logic [DIV_W-1:0]   pre_q;
  logic [WIDTH-1:0]   lvl_q [CHANNELS];
  logic               valid_q;
  logic               done_q;

  logic                      stall;
  logic                      tick;
  logic                      any_nz;
  logic [WIDTH-1:0]          act_lvl;
  logic [CHANNELS*WIDTH-1:0] data_w;

  // A stalled frame freezes everything, so tick needs no extra gating:
  // the whole update below is skipped while stalled.
  assign stall   = valid_q & ~leds.aso_LEDS_ready;
  assign tick    = (pre_q == coe_STEP_DIV);
  // In ALL mode ch_q stays 0 and every channel tracks channel 0.
  assign act_lvl = lvl_q[ch_q];

  always_comb begin
    any_nz = 1'b0;
    data_w = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      any_nz = any_nz | (lvl_q[i] != '0);
      data_w[(CHANNELS-i)*WIDTH-1 -: WIDTH] = lvl_q[i];
    end
  end

  assign leds.aso_LEDS_data  = data_w;
  assign leds.aso_LEDS_valid = valid_q;
  assign coe_CYCLE_DONE      = done_q;

  always_ff @(posedge csi_MCLK_clk) begin
    if (rsi_MRST_reset) begin
      state_q <= IDLE;
      ch_q    <= '0;
      mode_q  <= '0;
      pre_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) lvl_q[i] <= '0;
      valid_q <= 1'b1;             // initial zero frame
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!stall) begin
        // Any frame present here was just transferred (or none was pending);
        // a level change below re-raises valid on the same edge.
        valid_q <= 1'b0;
        pre_q   <= tick ? '0 : pre_q + 1'b1;
        case (state_q)
          IDLE: begin
            if (coe_EN) begin
              mode_q  <= coe_MODE;
              ch_q    <= '0;
              pre_q   <= '0;
              state_q <= RAMP_UP;
            end
          end
          RAMP_UP, RAMP_DOWN: begin
            if (!coe_EN) begin
              for (int i = 0; i < CHANNELS; i++) lvl_q[i] <= '0;
              valid_q <= any_nz;
              state_q <= IDLE;
            end else if (tick && mode_q != M_HOLD) begin
              valid_q <= 1'b1;
              for (int i = 0; i < CHANNELS; i++) begin
                if (mode_q == M_ALL || CH_W'(i) == ch_q)
                  lvl_q[i] <= (state_q == RAMP_UP) ? lvl_q[i] + 1'b1 : lvl_q[i] - 1'b1;
              end
              // Turnaround decided on the step that lands on the limit, so
              // levels never leave 0..MAX.
              if (state_q == RAMP_UP && act_lvl == MAX - 1'b1)
                state_q <= (mode_q == M_SAW) ? ADVANCE : RAMP_DOWN;
              else if (state_q == RAMP_DOWN && act_lvl == WIDTH'(1))
                state_q <= ADVANCE;
            end
          end
          ADVANCE: begin
            if (mode_q == M_SAW) begin
              lvl_q[ch_q] <= '0;
              valid_q     <= 1'b1;
            end
            if (ch_q == CH_W'(CHANNELS-1) || mode_q == M_ALL) begin
              ch_q   <= '0;
              done_q <= 1'b1;
              mode_q <= coe_MODE;
            end else begin
              ch_q <= ch_q + 1'b1;
            end
            pre_q   <= '0;
            state_q <= coe_EN ? RAMP_UP : IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rgb_led_fade_seq.sv
module tb_rgb_led_fade_seq;
  localparam int C      = 3;
  localparam int W      = 4;
  localparam int DW     = 19;
  localparam int MAXV   = (1 << W) - 1;
  localparam int DATA_W = C * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [DW-1:0] div  = '0;
  logic          done;

  rgb_led_fade_seq_if #(.DATA_W(DATA_W)) bus ();

  rgb_led_fade_seq #(.CHANNELS(C), .WIDTH(W), .DIV_W(DW)) dut (
    .csi_MCLK_clk   (clk),
    .rsi_MRST_reset (rst),
    .coe_EN         (en),
    .coe_MODE       (mode),
    .coe_STEP_DIV   (div),
    .leds           (bus),
    .coe_CYCLE_DONE (done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  bit chk_en   = 1'b0;
  logic [DATA_W-1:0] expq [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted frame is compared against the next expected one.
  always @(negedge clk) begin
    if (!rst && done) done_cnt++;
    if (!rst && chk_en && bus.aso_LEDS_valid && bus.aso_LEDS_ready) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL frame_unexpected: got %0h expected no frame (cycle %0d)",
                 bus.aso_LEDS_data, cyc);
      end else begin
        chk("frame", bus.aso_LEDS_data, expq.pop_front());
      end
    end
  end

  // Reference model: frame values derived from the sequencing rules.
  function automatic logic [DATA_W-1:0] one(int c, int v);
    logic [DATA_W-1:0] r;
    r = DATA_W'(v) << ((C - 1 - c) * W);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] all_lv(int v);
    logic [DATA_W-1:0] r = '0;
    for (int c = 0; c < C; c++) r = r | one(c, v);
    return r;
  endfunction

  task automatic push_frames(int m, int n);
    for (int k = 0; k < n; k++) begin
      if (m == 1) begin
        for (int v = 1; v <= MAXV; v++) expq.push_back(all_lv(v));
        for (int v = MAXV - 1; v >= 0; v--) expq.push_back(all_lv(v));
      end else begin
        for (int c = 0; c < C; c++) begin
          for (int v = 1; v <= MAXV; v++) expq.push_back(one(c, v));
          if (m == 2) expq.push_back('0);
          else for (int v = MAXV - 1; v >= 0; v--) expq.push_back(one(c, v));
        end
      end
    end
  endtask

  function automatic int period(int m, int d);
    if (m == 1) return 2 * MAXV * (d + 1) + 1;
    if (m == 0) return C * (2 * MAXV * (d + 1) + 1);
    return C * (MAXV * (d + 1) + 1);
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Runs until n CYCLE_DONE pulses, then drops EN.
  task automatic wait_done(int n, int per, bit rnd);
    int nd = 0;
    int last = 0;
    int budget = 30000;
    while (nd < n && budget > 0) begin
      step();
      if (rnd) bus.aso_LEDS_ready = ($urandom_range(0, 3) != 0);
      if (done) begin
        if (per > 0 && nd > 0) chk("done_period", cyc - last, per);
        last = cyc;
        nd++;
      end
      budget--;
    end
    if (nd < n) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got %0d pulses expected %0d", nd, n);
    end
    en = 1'b0;
    bus.aso_LEDS_ready = 1'b1;
  endtask

  task automatic drain();
    int budget = 500;
    while (expq.size() != 0 && budget > 0) begin
      step();
      budget--;
    end
    repeat (3) step();
    chk("drain_left", expq.size(), 0);
  endtask

  task automatic wait_data(logic [DATA_W-1:0] v, string nm);
    int budget = 2000;
    while (bus.aso_LEDS_data != v && budget > 0) begin
      step();
      budget--;
    end
    chk(nm, bus.aso_LEDS_data, v);
  endtask

  task automatic run_mode(int m, int d, int n, bit rnd);
    push_frames(m, n);
    mode = 2'(m);
    div  = DW'(d);
    en   = 1'b1;
    wait_done(n, rnd ? 0 : period(m, d), rnd);
    drain();
  endtask

  initial begin
    int d0;
    int prev_c;
    int nint;
    int budget;
    logic [DATA_W-1:0] prev;

    // Reset and idle: one zero frame, then nothing.
    bus.aso_LEDS_ready = 1'b1;
    repeat (3) step();
    chk("rst_data", bus.aso_LEDS_data, 0);
    chk("rst_valid", bus.aso_LEDS_valid, 1);
    chk("rst_done", done, 0);
    expq.push_back('0);
    chk_en = 1'b1;
    rst = 1'b0;
    step();
    chk("idle_valid_drop", bus.aso_LEDS_valid, 0);
    repeat (20) step();
    chk("idle_valid", bus.aso_LEDS_valid, 0);
    chk("idle_no_done", done_cnt, 0);
    chk("idle_drain", expq.size(), 0);

    // Directed modes, no backpressure, with CYCLE_DONE spacing.
    run_mode(0, 0, 2, 1'b0);
    run_mode(1, 0, 3, 1'b0);
    run_mode(2, 0, 2, 1'b0);

    // Randomized modes/dividers with random backpressure.
    for (int it = 0; it < 5; it++)
      run_mode($urandom_range(0, 2), $urandom_range(0, 2), 1, 1'b1);

    // HOLD: no frames, no CYCLE_DONE.
    d0 = done_cnt;
    mode = 2'd3;
    div = '0;
    en = 1'b1;
    repeat (40) step();
    en = 1'b0;
    repeat (5) step();
    chk("hold_no_done", done_cnt - d0, 0);
    chk("hold_valid", bus.aso_LEDS_valid, 0);

    // Stall mid-ramp with STEP_DIV=3.
    push_frames(0, 1);
    mode = 2'd0;
    div = DW'(3);
    en = 1'b1;
    wait_data(one(0, 5), "stall_reach");
    bus.aso_LEDS_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_data", bus.aso_LEDS_data, one(0, 5));
      chk("stall_valid", bus.aso_LEDS_valid, 1);
    end
    bus.aso_LEDS_ready = 1'b1;
    prev = bus.aso_LEDS_data;
    prev_c = -1;
    nint = 0;
    budget = 100;
    while (nint < 3 && budget > 0) begin
      step();
      if (bus.aso_LEDS_data != prev) begin
        if (prev_c >= 0) begin
          chk("step_spacing", cyc - prev_c, 4);
          nint++;
        end
        prev_c = cyc;
        prev = bus.aso_LEDS_data;
      end
      budget--;
    end
    chk("step_spacing_seen", nint, 3);
    wait_done(1, 0, 1'b0);
    drain();

    // EN dropped while channel 1 sits at 9 on the way up.
    d0 = done_cnt;
    for (int v = 1; v <= MAXV; v++) expq.push_back(one(0, v));
    for (int v = MAXV - 1; v >= 0; v--) expq.push_back(one(0, v));
    for (int v = 1; v <= 9; v++) expq.push_back(one(1, v));
    expq.push_back('0);
    mode = 2'd0;
    div = '0;
    en = 1'b1;
    wait_data(one(1, 9), "en_drop_reach");
    en = 1'b0;
    step();
    chk("en_drop_data", bus.aso_LEDS_data, 0);
    chk("en_drop_valid", bus.aso_LEDS_valid, 1);
    drain();
    chk("en_drop_no_done", done_cnt - d0, 0);
    chk("en_drop_idle", bus.aso_LEDS_valid, 0);

    // Reset mid-ramp discards the pending stream.
    chk_en = 1'b0;
    expq.delete();
    en = 1'b1;
    wait_data(one(0, 3), "rst_mid_reach");
    rst = 1'b1;
    en = 1'b0;
    step();
    chk("rst_mid_data", bus.aso_LEDS_data, 0);
    chk("rst_mid_valid", bus.aso_LEDS_valid, 1);
    chk("rst_mid_done", done, 0);
    expq.push_back('0);
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (20) step();
    chk("rst_mid_idle", bus.aso_LEDS_valid, 0);
    chk("rst_mid_drain", expq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
